// File: rtl/pipelined_mips_cpu_pkg.sv
// Shared ISA constants, ALU operation encoding and pipeline-register layouts.
// Latency: n/a (types only).
// Backpressure: n/a.
package pipelined_mips_cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_MUL = 6'h18;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_WB   = 2'd1;
    localparam logic [1:0] FWD_MEM  = 2'd2;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_MUL
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src;
        alu_op_e     alu_op;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
    } id_ex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] alu_res;
        logic [31:0] store_dat;
        logic [4:0]  dst;
    } ex_mem_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] alu_res;
        logic [31:0] load_dat;
        logic [4:0]  dst;
    } mem_wb_t;

endpackage

// File: rtl/pipelined_mips_cpu_hazard_forward_unit.sv
// Load-use stall detection and EX operand forwarding selects.
// Latency: purely combinational.
// Backpressure: stall_o freezes PC and IF/ID and bubbles ID/EX for one cycle.
module pipelined_mips_cpu_hazard_forward_unit
    import pipelined_mips_cpu_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rs_i,
    input  logic [4:0] ex_rt_i,
    input  logic       mem_reg_write_i,
    input  logic [4:0] mem_dst_i,
    input  logic       wb_reg_write_i,
    input  logic [4:0] wb_dst_i,
    output logic       stall_o,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o
);

    // The younger EX/MEM result wins over MEM/WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic mem_we, input logic [4:0] mem_dst,
                                           input logic wb_we, input logic [4:0] wb_dst);
        logic [1:0] sel;
        sel = FWD_NONE;
        if (mem_we && mem_dst != 5'd0 && mem_dst == src) begin
            sel = FWD_MEM;
        end else if (wb_we && wb_dst != 5'd0 && wb_dst == src) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        stall_o = ex_mem_read_i && ex_rt_i != 5'd0 &&
                  (ex_rt_i == id_rs_i || ex_rt_i == id_rt_i);
        fwd_a_o = fwd_sel(ex_rs_i, mem_reg_write_i, mem_dst_i, wb_reg_write_i, wb_dst_i);
        fwd_b_o = fwd_sel(ex_rt_i, mem_reg_write_i, mem_dst_i, wb_reg_write_i, wb_dst_i);
    end

endmodule

// File: rtl/pipelined_mips_cpu.sv
// Five-stage MIPS-subset core with internal instruction/data memories and register file.
// Latency: one instruction per cycle; +1 cycle per load-use stall or taken branch/jump.
// Backpressure: start_i low holds PC and feeds bubbles; load-use stall holds PC and IF/ID.
module pipelined_mips_cpu
    import pipelined_mips_cpu_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_BYTES = 32
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic start_i
);

    localparam int DA_W = $clog2(DMEM_BYTES);

    if_id_t  if_id_q,  if_id_d;
    id_ex_t  id_ex_q,  id_ex_d;
    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;

    logic [31:0] pc_d, pc4, instr;
    logic        stall, take, Flush;
    logic [31:0] redirect_tgt, rs_val, rt_val, wb_val;
    logic [5:0]  id_op, id_fn;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_imm;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] opa, opb, opb_reg, alu_res, load_dat;
    logic [DA_W-1:0] dm_a0, dm_a1, dm_a2, dm_a3;

    if (1'b1) begin : PC
        logic [31:0] pc_o;
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) pc_o <= '0;
            else          pc_o <= pc_d;
        end
    end

    if (1'b1) begin : Instruction_Memory
        logic [31:0] memory [IMEM_WORDS];
    end

    if (1'b1) begin : Registers
        logic [31:0] register [32];
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                for (int i = 0; i < 32; i++) register[i] <= '0;
            end else if (mem_wb_q.reg_write && mem_wb_q.dst != 5'd0) begin
                register[mem_wb_q.dst] <= wb_val;
            end
        end
    end

    if (1'b1) begin : Data_Memory
        logic [7:0] memory [DMEM_BYTES];
        always_ff @(posedge clk_i) begin
            if (ex_mem_q.mem_write) begin
                memory[dm_a0] <= ex_mem_q.store_dat[7:0];
                memory[dm_a1] <= ex_mem_q.store_dat[15:8];
                memory[dm_a2] <= ex_mem_q.store_dat[23:16];
                memory[dm_a3] <= ex_mem_q.store_dat[31:24];
            end
        end
    end

    // IF
    assign pc4   = PC.pc_o + 32'd4;
    assign instr = Instruction_Memory.memory[PC.pc_o[9:2]];

    always_comb begin
        pc_d = PC.pc_o;
        if_id_d = '0;
        if (stall) begin
            if_id_d = if_id_q;
        end else if (take) begin
            pc_d = redirect_tgt;
        end else if (start_i) begin
            pc_d = pc4;
            if_id_d = '{pc4: pc4, instr: instr};
        end
    end

    // ID
    assign id_op  = if_id_q.instr[31:26];
    assign id_rs  = if_id_q.instr[25:21];
    assign id_rt  = if_id_q.instr[20:16];
    assign id_rd  = if_id_q.instr[15:11];
    assign id_fn  = if_id_q.instr[5:0];
    assign id_imm = {{16{if_id_q.instr[15]}}, if_id_q.instr[15:0]};

    // Same-cycle WB write is visible here; r0 is never written so it reads 0.
    always_comb begin
        rs_val = Registers.register[id_rs];
        rt_val = Registers.register[id_rt];
        if (mem_wb_q.reg_write && mem_wb_q.dst != 5'd0) begin
            if (mem_wb_q.dst == id_rs) rs_val = wb_val;
            if (mem_wb_q.dst == id_rt) rt_val = wb_val;
        end
    end

    always_comb begin
        take = 1'b0;
        redirect_tgt = if_id_q.pc4 + (id_imm << 2);
        if (id_op == OP_J) begin
            redirect_tgt = {if_id_q.pc4[31:28], if_id_q.instr[25:0], 2'b00};
            take = !stall;
        end else if (id_op == OP_BEQ) begin
            take = !stall && (rs_val == rt_val);
        end
    end
    assign Flush = take;

    always_comb begin
        id_ex_d = '0;
        if (!stall) begin
            id_ex_d.rs_val = rs_val;
            id_ex_d.rt_val = rt_val;
            id_ex_d.imm    = id_imm;
            id_ex_d.rs     = id_rs;
            id_ex_d.rt     = id_rt;
            case (id_op)
                OP_RTYPE: begin
                    id_ex_d.dst       = id_rd;
                    id_ex_d.reg_write = 1'b1;
                    case (id_fn)
                        FN_ADD:  id_ex_d.alu_op = ALU_ADD;
                        FN_SUB:  id_ex_d.alu_op = ALU_SUB;
                        FN_AND:  id_ex_d.alu_op = ALU_AND;
                        FN_OR:   id_ex_d.alu_op = ALU_OR;
                        FN_MUL:  id_ex_d.alu_op = ALU_MUL;
                        default: id_ex_d.reg_write = 1'b0;
                    endcase
                end
                OP_ADDI: begin
                    id_ex_d.dst       = id_rt;
                    id_ex_d.reg_write = 1'b1;
                    id_ex_d.alu_src   = 1'b1;
                end
                OP_LW: begin
                    id_ex_d.dst       = id_rt;
                    id_ex_d.reg_write = 1'b1;
                    id_ex_d.mem_read  = 1'b1;
                    id_ex_d.alu_src   = 1'b1;
                end
                OP_SW: begin
                    id_ex_d.mem_write = 1'b1;
                    id_ex_d.alu_src   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    pipelined_mips_cpu_hazard_forward_unit Hazard_Detection (
        .id_rs_i         (id_rs),
        .id_rt_i         (id_rt),
        .ex_mem_read_i   (id_ex_q.mem_read),
        .ex_rs_i         (id_ex_q.rs),
        .ex_rt_i         (id_ex_q.rt),
        .mem_reg_write_i (ex_mem_q.reg_write),
        .mem_dst_i       (ex_mem_q.dst),
        .wb_reg_write_i  (mem_wb_q.reg_write),
        .wb_dst_i        (mem_wb_q.dst),
        .stall_o         (stall),
        .fwd_a_o         (fwd_a),
        .fwd_b_o         (fwd_b)
    );

    // EX
    always_comb begin
        case (fwd_a)
            FWD_MEM: opa = ex_mem_q.alu_res;
            FWD_WB:  opa = wb_val;
            default: opa = id_ex_q.rs_val;
        endcase
        case (fwd_b)
            FWD_MEM: opb_reg = ex_mem_q.alu_res;
            FWD_WB:  opb_reg = wb_val;
            default: opb_reg = id_ex_q.rt_val;
        endcase
        opb = id_ex_q.alu_src ? id_ex_q.imm : opb_reg;
        case (id_ex_q.alu_op)
            ALU_SUB: alu_res = opa - opb;
            ALU_AND: alu_res = opa & opb;
            ALU_OR:  alu_res = opa | opb;
            ALU_MUL: alu_res = opa * opb;
            default: alu_res = opa + opb;
        endcase
        ex_mem_d = '{reg_write: id_ex_q.reg_write, mem_read: id_ex_q.mem_read,
                     mem_write: id_ex_q.mem_write, alu_res: alu_res,
                     store_dat: opb_reg, dst: id_ex_q.dst};
    end

    // MEM: little-endian word over four bytes, address wrapping within the array
    always_comb begin
        dm_a0 = ex_mem_q.alu_res[DA_W-1:0];
        dm_a1 = dm_a0 + DA_W'(1);
        dm_a2 = dm_a0 + DA_W'(2);
        dm_a3 = dm_a0 + DA_W'(3);
        load_dat = {Data_Memory.memory[dm_a3], Data_Memory.memory[dm_a2],
                    Data_Memory.memory[dm_a1], Data_Memory.memory[dm_a0]};
        mem_wb_d = '{reg_write: ex_mem_q.reg_write, mem_to_reg: ex_mem_q.mem_read,
                     alu_res: ex_mem_q.alu_res, load_dat: load_dat, dst: ex_mem_q.dst};
    end

    // WB
    assign wb_val = mem_wb_q.mem_to_reg ? mem_wb_q.load_dat : mem_wb_q.alu_res;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            if_id_q  <= '0;
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            if_id_q  <= if_id_d;
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

endmodule

// File: tb/tb_pipelined_mips_cpu.sv
// Directed programs for the MIPS pipeline; expectations queued and checked by a monitor.
module tb_pipelined_mips_cpu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    always #5 clk = ~clk;

    pipelined_mips_cpu #(.IMEM_WORDS(256), .DMEM_BYTES(32)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start)
    );

    typedef enum int {K_REG, K_MEM, K_PC, K_FLUSH, K_STALL} kind_e;
    typedef struct {
        string       name;
        kind_e       kind;
        int          idx;
        logic [31:0] exp;
    } chk_t;

    chk_t        sb[$];
    logic [31:0] prog[$];
    int n_cmp = 0;
    int n_bad = 0;
    int flush_cnt = 0;
    int stall_cnt = 0;

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] addr);
        return {6'h02, addr};
    endfunction

    task automatic expect_val(input string nm, input kind_e k, input int idx, input logic [31:0] e);
        chk_t c;
        c.name = nm;
        c.kind = k;
        c.idx  = idx;
        c.exp  = e;
        sb.push_back(c);
    endtask

    // Assert reset, load the current program, clear data memory.
    task automatic begin_test();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 256; i++)
            dut.Instruction_Memory.memory[i] = (i < prog.size()) ? prog[i] : 32'h0;
        for (int i = 0; i < 32; i++)
            dut.Data_Memory.memory[i] = 8'h00;
        @(negedge clk);
    endtask

    task automatic run(input int cycles);
        rst_n = 1'b1;
        start = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            flush_cnt = 0;
            stall_cnt = 0;
        end else begin
            if (dut.Flush) flush_cnt++;
            if (dut.stall) stall_cnt++;
        end
    end

    // Monitor: drain expectations just after each falling edge, while state is stable.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            while (sb.size() > 0) begin
                chk_t c;
                logic [31:0] act;
                c = sb.pop_front();
                case (c.kind)
                    K_REG:   act = dut.Registers.register[c.idx];
                    K_MEM:   act = {dut.Data_Memory.memory[(c.idx + 3) % 32],
                                    dut.Data_Memory.memory[(c.idx + 2) % 32],
                                    dut.Data_Memory.memory[(c.idx + 1) % 32],
                                    dut.Data_Memory.memory[c.idx % 32]};
                    K_PC:    act = dut.PC.pc_o;
                    K_FLUSH: act = 32'(flush_cnt);
                    default: act = 32'(stall_cnt);
                endcase
                n_cmp++;
                if (act !== c.exp) begin
                    n_bad++;
                    $display("FAIL %s: actual=0x%08h required=0x%08h", c.name, act, c.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and start sequencing with an all-NOP program.
        prog = {};
        begin_test();
        expect_val("reset_pc", K_PC, 0, 32'd0);
        expect_val("reset_r31", K_REG, 31, 32'd0);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk); expect_val("pc_step1", K_PC, 0, 32'd4);
        @(negedge clk); expect_val("pc_step2", K_PC, 0, 32'd8);
        @(negedge clk); expect_val("pc_step3", K_PC, 0, 32'd12);
        start = 1'b0;
        @(negedge clk); expect_val("pc_hold1", K_PC, 0, 32'd12);
        @(negedge clk); expect_val("pc_hold2", K_PC, 0, 32'd12);
        start = 1'b1;
        @(negedge clk); expect_val("pc_resume", K_PC, 0, 32'd16);

        // Back-to-back forwarding.
        prog = {enc_i(6'h08, 5'd8, 5'd0, 16'd5),
                enc_i(6'h08, 5'd9, 5'd8, 16'd3),
                enc_r(6'h20, 5'd10, 5'd9, 5'd8),
                enc_r(6'h22, 5'd11, 5'd10, 5'd9)};
        begin_test();
        run(12);
        expect_val("fwd_r8", K_REG, 8, 32'd5);
        expect_val("fwd_r9", K_REG, 9, 32'd8);
        expect_val("fwd_r10", K_REG, 10, 32'd13);
        expect_val("fwd_r11", K_REG, 11, 32'd5);
        expect_val("fwd_flush", K_FLUSH, 0, 32'd0);
        expect_val("fwd_stall", K_STALL, 0, 32'd0);

        // and / or with forwarding: 12 & 10 = 8, 12 | 10 = 14.
        prog = {enc_i(6'h08, 5'd8, 5'd0, 16'd12),
                enc_i(6'h08, 5'd9, 5'd0, 16'd10),
                enc_r(6'h24, 5'd10, 5'd8, 5'd9),
                enc_r(6'h25, 5'd11, 5'd8, 5'd9)};
        begin_test();
        run(12);
        expect_val("and_r10", K_REG, 10, 32'd8);
        expect_val("or_r11", K_REG, 11, 32'd14);

        // Load-use stall followed by forwarded store data.
        prog = {enc_i(6'h23, 5'd8, 5'd0, 16'd0),
                enc_r(6'h20, 5'd9, 5'd8, 5'd8),
                enc_i(6'h2B, 5'd9, 5'd0, 16'd4)};
        begin_test();
        dut.Data_Memory.memory[0] = 8'd5;
        run(12);
        expect_val("lu_r9", K_REG, 9, 32'd10);
        expect_val("lu_dmem4", K_MEM, 4, 32'd10);
        expect_val("lu_stall", K_STALL, 0, 32'd1);
        expect_val("lu_flush", K_FLUSH, 0, 32'd0);

        // Taken beq skips one instruction.
        prog = {enc_i(6'h08, 5'd8, 5'd0, 16'd1),
                enc_i(6'h04, 5'd8, 5'd8, 16'd1),
                enc_i(6'h08, 5'd9, 5'd0, 16'd7),
                enc_i(6'h08, 5'd10, 5'd0, 16'd9)};
        begin_test();
        run(12);
        expect_val("beq_r9", K_REG, 9, 32'd0);
        expect_val("beq_r10", K_REG, 10, 32'd9);
        expect_val("beq_flush", K_FLUSH, 0, 32'd1);

        // Not-taken beq (r8=1 vs r0), spaced so r8 is in the register file.
        prog = {enc_i(6'h08, 5'd8, 5'd0, 16'd1),
                32'h0, 32'h0, 32'h0,
                enc_i(6'h04, 5'd0, 5'd8, 16'd1),
                enc_i(6'h08, 5'd9, 5'd0, 16'd7),
                enc_i(6'h08, 5'd10, 5'd0, 16'd9)};
        begin_test();
        run(14);
        expect_val("bnt_r9", K_REG, 9, 32'd7);
        expect_val("bnt_r10", K_REG, 10, 32'd9);
        expect_val("bnt_flush", K_FLUSH, 0, 32'd0);

        // Jump to word 4.
        prog = {enc_j(26'd4),
                enc_i(6'h08, 5'd9, 5'd0, 16'd7),
                enc_i(6'h08, 5'd9, 5'd0, 16'd7),
                enc_i(6'h08, 5'd9, 5'd0, 16'd7),
                enc_i(6'h08, 5'd10, 5'd0, 16'd9)};
        begin_test();
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk); expect_val("j_pc_fetch", K_PC, 0, 32'd4);
        @(negedge clk); expect_val("j_pc_target", K_PC, 0, 32'd16);
        @(negedge clk); expect_val("j_pc_next", K_PC, 0, 32'd20);
        repeat (8) @(negedge clk);
        expect_val("j_r9", K_REG, 9, 32'd0);
        expect_val("j_r10", K_REG, 10, 32'd9);
        expect_val("j_flush", K_FLUSH, 0, 32'd1);

        // Factorial of dmem[0]=5 into dmem[4], then a write attempt to r0.
        prog = {enc_i(6'h23, 5'd8, 5'd0, 16'd0),
                enc_i(6'h08, 5'd9, 5'd0, 16'd1),
                enc_r(6'h18, 5'd9, 5'd9, 5'd8),
                enc_i(6'h08, 5'd8, 5'd8, 16'hFFFF),
                32'h0, 32'h0, 32'h0,
                enc_i(6'h04, 5'd0, 5'd8, 16'd1),
                enc_j(26'd2),
                enc_i(6'h2B, 5'd9, 5'd0, 16'd4),
                enc_i(6'h08, 5'd0, 5'd0, 16'd7)};
        begin_test();
        dut.Data_Memory.memory[0] = 8'd5;
        run(130);
        expect_val("fact_dmem4", K_MEM, 4, 32'd120);
        expect_val("fact_dmem0", K_MEM, 0, 32'd5);
        expect_val("fact_r9", K_REG, 9, 32'd120);
        expect_val("fact_r8", K_REG, 8, 32'd0);
        expect_val("fact_r0", K_REG, 0, 32'd0);
        expect_val("fact_flush", K_FLUSH, 0, 32'd5);
        expect_val("fact_stall", K_STALL, 0, 32'd0);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: actual=%0d pending required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
